// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a mem_ready handshake and timeout.
// Optional CPU_SEQ_PERF_CNT_EN adds saturating cycle_cnt / instr_cnt outputs.
module cpu_seq_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        imem_rd,
  output logic        ir_load,
  output logic        alu_en,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        rf_we,
  output logic        pc_en,
  output logic        jmp,
  output logic        halted,
  output logic        err,
`ifdef CPU_SEQ_PERF_CNT_EN
  output logic [15:0] cycle_cnt,
  output logic [15:0] instr_cnt,
`endif
  output logic [2:0]  state
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || ADDR_WIDTH < 1) begin : g_bad_param
    $error("cpu_seq_ctrl: MEM_TIMEOUT must be 1..255 and ADDR_WIDTH >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_AND   = 4'h3,
    OP_OR    = 4'h4,
    OP_LOAD  = 4'h5,
    OP_STORE = 4'h6,
    OP_JMP   = 4'h7,
    OP_JZ    = 4'h8,
    OP_HALT  = 4'hF
  } opcode_t;

  // Last wait cycle index: a miss here makes the count reach MEM_TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur, nxt;
  opcode_t    op_q, op_cur;
  logic [7:0] wait_cnt;
  logic       err_set;
  logic       tmo;

  assign state = cur;

  // Next state plus the handshake/decode-dependent strobes, which must react in-cycle.
  always_comb begin
    nxt     = cur;
    err_set = 1'b0;
    ir_load = 1'b0;
    pc_en   = 1'b0;
    jmp     = 1'b0;
    op_cur  = (cur == S_DECODE) ? opcode_t'(opcode) : op_q;
    tmo     = (wait_cnt == TO_LAST) && !mem_ready;
    case (cur)
      S_IDLE:   if (start) nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ir_load = 1'b1;
          nxt     = S_DECODE;
        end else if (tmo) begin
          err_set = 1'b1;
          nxt     = S_HALT;
        end
      end
      S_DECODE: begin
        case (op_cur)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD, OP_STORE: nxt = S_EXEC;
          OP_NOP: begin
            pc_en = 1'b1;
            nxt   = S_FETCH;
          end
          OP_JMP: begin
            pc_en = 1'b1;
            jmp   = 1'b1;
            nxt   = S_FETCH;
          end
          OP_JZ: begin
            pc_en = 1'b1;
            jmp   = zero_flag;
            nxt   = S_FETCH;
          end
          OP_HALT: nxt = S_HALT;
          default: begin
            err_set = 1'b1;
            nxt     = S_HALT;
          end
        endcase
      end
      S_EXEC:   nxt = (op_q == OP_LOAD || op_q == OP_STORE) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            pc_en = 1'b1;
            nxt   = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (tmo) begin
          err_set = 1'b1;
          nxt     = S_HALT;
        end
      end
      S_WB: begin
        pc_en = 1'b1;
        nxt   = S_FETCH;
      end
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
    // An instruction aborted by reset never retires.
    if (!rst) begin
      ir_load = 1'b0;
      pc_en   = 1'b0;
      jmp     = 1'b0;
    end
  end

  // Level strobes are registered from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur      <= S_IDLE;
      op_q     <= OP_NOP;
      wait_cnt <= '0;
      err      <= 1'b0;
      imem_rd  <= 1'b0;
      alu_en   <= 1'b0;
      dmem_rd  <= 1'b0;
      dmem_wr  <= 1'b0;
      rf_we    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      cur      <= nxt;
      op_q     <= op_cur;
      wait_cnt <= ((cur == S_FETCH || cur == S_MEM) && nxt == cur) ? wait_cnt + 8'd1 : '0;
      err      <= err | err_set;
      imem_rd  <= (nxt == S_FETCH);
      alu_en   <= (nxt == S_EXEC);
      dmem_rd  <= (nxt == S_MEM) && (op_cur == OP_LOAD);
      dmem_wr  <= (nxt == S_MEM) && (op_cur == OP_STORE);
      rf_we    <= (nxt == S_WB);
      halted   <= (nxt == S_HALT);
    end
  end

`ifdef CPU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (cur != S_IDLE && cur != S_HALT && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 16'd1;
      if (pc_en && instr_cnt != '1)
        instr_cnt <= instr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: directed per-cycle vectors pushed by stimulus, popped by a negedge monitor.
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, zero_flag, mem_ready;
  logic [3:0] opcode;
  logic       imem_rd, ir_load, alu_en, dmem_rd, dmem_wr, rf_we, pc_en, jmp, halted, err;
  logic [2:0] state;
`ifdef CPU_SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  cpu_seq_ctrl #(.ADDR_WIDTH(6), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .imem_rd(imem_rd), .ir_load(ir_load), .alu_en(alu_en),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .rf_we(rf_we), .pc_en(pc_en), .jmp(jmp),
    .halted(halted), .err(err),
`ifdef CPU_SEQ_PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt),
`endif
    .state(state)
  );

  // Expected vector: {imem_rd, ir_load, alu_en, dmem_rd, dmem_wr, rf_we, pc_en, jmp, halted, err, state[2:0]}
  localparam logic [12:0] F_IMR = 13'h1000, F_IRL = 13'h0800, F_ALU = 13'h0400, F_DRD = 13'h0200;
  localparam logic [12:0] F_DWR = 13'h0100, F_RFW = 13'h0080, F_PCE = 13'h0040, F_JMP = 13'h0020;
  localparam logic [12:0] F_HLT = 13'h0010, F_ERR = 13'h0008;
  localparam logic [12:0] T_IDLE = 13'd0, T_FETCH = 13'd1, T_DEC = 13'd2, T_EXEC = 13'd3;
  localparam logic [12:0] T_MEM = 13'd4, T_WB = 13'd5, T_HALT = 13'd6;

  typedef struct {
    logic [12:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge and queue the outputs expected for that cycle.
  task automatic step(input string tag, input logic s, input logic [3:0] op, input logic z,
                      input logic rdy, input logic r, input logic [12:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    start = s; opcode = op; zero_flag = z; mem_ready = rdy; rst = r;
    x.v = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic fetch_ok(input string tag);
    step(tag, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, F_IMR | F_IRL | T_FETCH);
  endtask

  initial begin : monitor
    exp_t x;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        act = {imem_rd, ir_load, alu_en, dmem_rd, dmem_wr, rf_we, pc_en, jmp, halted, err, state};
        check(x.tag, {19'd0, act}, {19'd0, x.v});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b0; start = 1'b0; opcode = 4'h0; zero_flag = 1'b0; mem_ready = 1'b0;
    step("rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, T_IDLE);
    step("idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, T_IDLE);
`ifdef CPU_SEQ_PERF_CNT_EN
    check("perf.rst", {cycle_cnt, instr_cnt}, 32'd0);
`endif
    // ADD, zero wait states; opcode changed after DECODE must be ignored
    step("alu.start", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, T_IDLE);
    fetch_ok("alu.fetch");
    step("alu.dec", 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, T_DEC);
    step("alu.exec", 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, F_ALU | T_EXEC);
    step("alu.wb", 1'b0, 4'h7, 1'b1, 1'b1, 1'b1, F_RFW | F_PCE | T_WB);
    // LOAD with 3 wait cycles in MEM
    fetch_ok("ld.fetch");
`ifdef CPU_SEQ_PERF_CNT_EN
    check("perf.alu", {cycle_cnt, instr_cnt}, {16'd4, 16'd1});
`endif
    step("ld.dec", 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, T_DEC);
    step("ld.exec", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, F_ALU | T_EXEC);
    for (int i = 0; i < 3; i++)
      step("ld.wait", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, F_DRD | T_MEM);
    step("ld.mem", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, F_DRD | T_MEM);
    step("ld.wb", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, F_RFW | F_PCE | T_WB);
    // JZ taken / not taken, JMP, NOP
    fetch_ok("jz1.fetch");
    step("jz1.dec", 1'b0, 4'h8, 1'b1, 1'b1, 1'b1, F_PCE | F_JMP | T_DEC);
    fetch_ok("jz0.fetch");
    step("jz0.dec", 1'b0, 4'h8, 1'b0, 1'b1, 1'b1, F_PCE | T_DEC);
    fetch_ok("jmp.fetch");
    step("jmp.dec", 1'b0, 4'h7, 1'b0, 1'b1, 1'b1, F_PCE | F_JMP | T_DEC);
    fetch_ok("nop.fetch");
    step("nop.dec", 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, F_PCE | T_DEC);
    // STORE, zero wait states
    fetch_ok("st.fetch");
    step("st.dec", 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, T_DEC);
    step("st.exec", 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, F_ALU | T_EXEC);
    step("st.mem", 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, F_DWR | F_PCE | T_MEM);
    // STORE aborted by reset while waiting
    fetch_ok("sta.fetch");
    step("sta.dec", 1'b0, 4'h6, 1'b0, 1'b1, 1'b1, T_DEC);
    step("sta.exec", 1'b0, 4'h6, 1'b0, 1'b0, 1'b1, F_ALU | T_EXEC);
    step("sta.wait", 1'b0, 4'h6, 1'b0, 1'b0, 1'b1, F_DWR | T_MEM);
    step("sta.rst", 1'b0, 4'h6, 1'b0, 1'b1, 1'b0, F_DWR | T_MEM);
    step("sta.idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, T_IDLE);
`ifdef CPU_SEQ_PERF_CNT_EN
    check("perf.abort", {cycle_cnt, instr_cnt}, 32'd0);
`endif
    // FETCH timeout: 15 wait cycles then HALT with err; start ignored in HALT
    step("to.start", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, T_IDLE);
    for (int i = 0; i < 15; i++)
      step("to.wait", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, F_IMR | T_FETCH);
    step("to.halt", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, F_HLT | F_ERR | T_HALT);
    step("to.stay", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, F_HLT | F_ERR | T_HALT);
    step("to.rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, F_HLT | F_ERR | T_HALT);
    step("to.clr", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, T_IDLE);
    // mem_ready on wait cycle 15 wins over the timeout
    step("nt.start", 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, T_IDLE);
    for (int i = 0; i < 14; i++)
      step("nt.wait", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, F_IMR | T_FETCH);
    step("nt.ready", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, F_IMR | F_IRL | T_FETCH);
    step("nt.dec", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, F_PCE | T_DEC);
    // Illegal opcode: sticky err until reset
    fetch_ok("ill.fetch");
    step("ill.dec", 1'b0, 4'hA, 1'b0, 1'b1, 1'b1, T_DEC);
    step("ill.halt", 1'b1, 4'h1, 1'b0, 1'b1, 1'b1, F_HLT | F_ERR | T_HALT);
    step("ill.stay", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, F_HLT | F_ERR | T_HALT);
    step("ill.rst", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, F_HLT | F_ERR | T_HALT);
    step("ill.clr", 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, T_IDLE);
    // HALT opcode: halted without err
    step("hlt.start", 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, T_IDLE);
    fetch_ok("hlt.fetch");
    step("hlt.dec", 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, T_DEC);
    step("hlt.halt", 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, F_HLT | T_HALT);
    repeat (2) @(posedge clk);
    check("drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
